// File: rtl/tohost_monitor_if.sv
// rtl/tohost_monitor_if.sv - data-memory write port observed by tohost_monitor
interface tohost_monitor_if;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  // The core drives the store port.
  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output wr_strb
  );

  // The monitor only observes it and never stalls the core.
  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data,
    input wr_strb
  );
endinterface

// File: rtl/tohost_monitor.sv
// rtl/tohost_monitor.sv - riscv-tests tohost end-of-test decoder, watchdog under TOHOST_MONITOR_WATCHDOG_EN
module tohost_monitor #(
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter logic [31:0] TIMEOUT     = 32'd5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  tohost_monitor_if.slave   wr,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [30:0]       test_num,
  output logic [31:0]       cycle_count
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic qual;
  logic pass_hit;
  logic fail_hit;
  logic wd_expire;

  // Only full-word stores to tohost while still running count as a verdict.
  assign qual     = wr.wr_en && (wr.wr_addr == TOHOST_ADDR) &&
                    (wr.wr_strb == 4'hF) && (state == ST_RUN);
  assign pass_hit = qual && (wr.wr_data == 32'h1);
  assign fail_hit = qual && wr.wr_data[0] && (wr.wr_data != 32'h1);

`ifdef TOHOST_MONITOR_WATCHDOG_EN
  assign wd_expire = (state == ST_RUN) && (cycle_count == TIMEOUT - 32'd1);
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign wd_expire      = 1'b0;
`endif

  // State register; reset clears everything without waiting for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: clr overrides everything, a write verdict overrides the watchdog.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ST_RUN;
    end else if (state == ST_RUN) begin
      if (pass_hit) begin
        state_nxt = ST_PASS;
      end else if (fail_hit) begin
        state_nxt = ST_FAIL;
      end else if (wd_expire) begin
        state_nxt = ST_TIMEOUT;
      end
    end
  end

  // Capture the failing test number on the edge the FAIL verdict lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_num <= 31'd0;
    end else if (clr) begin
      test_num <= 31'd0;
    end else if (fail_hit) begin
      test_num <= wr.wr_data[31:1];
    end
  end

  // Count RUN edges, including the one that terminates the test; freeze after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= 32'd0;
    end else if (clr) begin
      cycle_count <= 32'd0;
    end else if (state == ST_RUN) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  // Status flags decoded purely from registered state.
  always_comb begin
    done    = (state != ST_RUN);
    pass    = (state == ST_PASS);
    fail    = (state == ST_FAIL);
    timeout = (state == ST_TIMEOUT);
  end

endmodule
